// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
// Digit limits describe an MM:SS chain, least significant digit first.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } state_t;

    typedef enum logic {
        UP,
        DOWN
    } mode_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX [4] = '{4'd9, 4'd5, 4'd9, 4'd5};

    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] mx
    );
        return (d > mx) ? mx : d;
    endfunction

endpackage

// File: rtl/stopwatch_edge_det.sv
// Registered rising-edge detector for one synchronized button level.
// One event per press: high only in the first cycle the level is seen high.
module stopwatch_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_evt
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_btn;
        end
    end

    assign o_evt = i_btn & ~r_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: run/pause/clear/mode control for the digit chain.
// Optional STOPWATCH_CTRL_AUTO_RELOAD_EN: down-count terminal reloads and keeps running.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          btn_start_stop,
    input  logic                          btn_clear,
    input  logic                          btn_mode,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] preset,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          cnt_en,
    output logic                          cnt_reverse,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digit_set,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digit_rst,
    output logic                          running,
    output logic                          done
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    logic   w_ss;
    logic   w_clr;
    logic   w_md;
    logic   w_all_max;
    logic   w_term;
    logic   w_auto;
    logic   [W-1:0] w_load_val;
    state_t r_state;
    state_t w_state_nxt;
    mode_t  r_mode;
    mode_t  w_mode_nxt;
    logic   [W-1:0] r_set;
    logic   [W-1:0] r_rst;

    stopwatch_edge_det u_ss  (.clk(clk), .reset(reset), .i_btn(btn_start_stop), .o_evt(w_ss));
    stopwatch_edge_det u_clr (.clk(clk), .reset(reset), .i_btn(btn_clear),      .o_evt(w_clr));
    stopwatch_edge_det u_md  (.clk(clk), .reset(reset), .i_btn(btn_mode),       .o_evt(w_md));

    // Terminal detection and clamped preset, both straight off the inputs.
    always_comb begin
        w_all_max  = 1'b1;
        w_load_val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits[i*DIGIT_W +: DIGIT_W] != DIGIT_MAX[i%4]) begin
                w_all_max = 1'b0;
            end
            w_load_val[i*DIGIT_W +: DIGIT_W] =
                clamp_digit(preset[i*DIGIT_W +: DIGIT_W], DIGIT_MAX[i%4]);
        end
        w_term = (r_mode == DOWN) ? (digits == '0) : w_all_max;
    end

`ifdef STOPWATCH_CTRL_AUTO_RELOAD_EN
    logic r_reload;

    assign w_auto = (r_state == RUN) & ~w_clr & ~w_ss & tick & w_term & (r_mode == DOWN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reload <= 1'b0;
        end else begin
            r_reload <= w_auto;
        end
    end
`else
    logic r_reload;

    assign w_auto   = 1'b0;
    assign r_reload = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= UP;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        unique case (r_state)
            IDLE: begin
                if (w_clr) begin
                    w_state_nxt = LOAD;
                end else if (w_ss) begin
                    w_state_nxt = RUN;
                end
                if (w_md) begin
                    w_mode_nxt = (r_mode == UP) ? DOWN : UP;
                end
            end
            LOAD: begin
                w_state_nxt = r_reload ? RUN : IDLE;
            end
            RUN: begin
                if (w_clr) begin
                    w_state_nxt = LOAD;
                end else if (w_ss) begin
                    w_state_nxt = PAUSE;
                end else if (w_auto) begin
                    w_state_nxt = LOAD;
                end else if (tick && w_term) begin
                    w_state_nxt = DONE;
                end
            end
            PAUSE: begin
                if (w_clr) begin
                    w_state_nxt = LOAD;
                end else if (w_ss) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (w_clr) begin
                    w_state_nxt = LOAD;
                end
                if (w_md) begin
                    w_mode_nxt = (r_mode == UP) ? DOWN : UP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Set/reset vectors are registered on entry so they cover exactly the LOAD cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_set <= '0;
            r_rst <= '1;
        end else if (w_state_nxt == LOAD) begin
            if (w_mode_nxt == DOWN) begin
                r_set <= w_load_val;
                r_rst <= ~w_load_val;
            end else begin
                r_set <= '0;
                r_rst <= '1;
            end
        end else begin
            r_set <= '0;
            r_rst <= '0;
        end
    end

    assign cnt_en      = tick & (r_state == RUN) & ~w_term;
    assign cnt_reverse = (r_mode == DOWN);
    assign running     = (r_state == RUN);
    assign done        = (r_state == DONE) | w_auto;
    assign digit_set   = r_set;
    assign digit_rst   = r_rst;

endmodule
